freq_gate_counter: RTL and testbench

- Measurement front end of the cymometer; sits directly upstream of the OLED display top.
- Counts rising edges of an asynchronous input signal over a fixed gate window of clkin_50m cycles.
- Latches the count as a 30-bit binary frequency word that feeds the display's binary-to-BCD path.
- The word is held stable between updates, so the display can sample it at any time.

---
 rtl/cymometer_pkg.sv | 21 ++
 rtl/sig_sync_edge.sv | 28 ++
 rtl/freq_gate_counter.sv | 109 ++++++++++
 tb/tb_freq_gate_counter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cymometer_pkg.sv
// Shared constants for the cymometer: data width, default gate timing and
// the measurement FSM state encoding.
package cymometer_pkg;

  localparam int DATA_W              = 30;
  localparam int GATE_CYCLES_DEFAULT = 50_000_000;
  localparam int DEAD_CYCLES_DEFAULT = 16;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_GATE  = 2'd1;
  localparam state_t S_LATCH = 2'd2;
  localparam state_t S_DEAD  = 2'd3;

  // Counter width that still works for a terminal value of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sig_sync_edge.sv
// Brings an asynchronous signal into the clock domain through two flops and
// produces a one-cycle pulse for each rising edge using a third flop.
module sig_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_sig,
  output logic rise_p
);

  logic sync1;
  logic sync2;
  logic sync3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= async_sig;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise_p = sync2 & ~sync3;

endmodule

// File: rtl/freq_gate_counter.sv
// Gated edge counter: counts rising edges of sig_in over GATE_CYCLES clocks,
// latches the result into freq_data, idles DEAD_CYCLES clocks, repeats.
module freq_gate_counter
  import cymometer_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEFAULT,
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEFAULT,
  parameter int DATA_W      = cymometer_pkg::DATA_W
) (
  input  logic              clkin_50m,
  input  logic              sys_rst_n,
  input  logic              sig_in,
  input  logic              en,
  output logic [DATA_W-1:0] freq_data,
  output logic              data_valid,
  output logic              overflow,
  output logic              gate_active,
  output logic [1:0]        fsm_state
);

  localparam int GW = cnt_width(GATE_CYCLES);
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam logic [GW-1:0]     GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [DW-1:0]     DEAD_LAST = DW'(DEAD_CYCLES - 1);
  localparam logic [DATA_W-1:0] EDGE_MAX  = '1;

  state_t            state;
  state_t            state_next;
  logic [GW-1:0]     gate_cnt;
  logic [DW-1:0]     dead_cnt;
  logic [DATA_W-1:0] edge_cnt;
  logic              sat;
  logic              rise_p;

  sig_sync_edge u_sync (
    .clk       (clkin_50m),
    .rst_n     (sys_rst_n),
    .async_sig (sig_in),
    .rise_p    (rise_p)
  );

  always_ff @(posedge clkin_50m or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_next;
  end

  // Dropping en mid-gate abandons the partial count; a started latch always completes.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (en) state_next = S_GATE;
      S_GATE: begin
        if (!en)                         state_next = S_IDLE;
        else if (gate_cnt == GATE_LAST) state_next = S_LATCH;
      end
      S_LATCH: state_next = S_DEAD;
      S_DEAD:  if (dead_cnt == DEAD_LAST) state_next = en ? S_GATE : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // data_valid is a one-cycle qualifier for the freq_data value that appears
  // on the following edge; there is no ready, the consumer cannot stall it.
  always_comb begin
    data_valid  = (state == S_LATCH);
    gate_active = (state == S_GATE);
    fsm_state   = state;
  end

  // Counters hold through S_LATCH so the latch sees the final gate count.
  always_ff @(posedge clkin_50m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
    end else if (state == S_GATE) begin
      if (gate_cnt != GATE_LAST) gate_cnt <= gate_cnt + 1'b1;
      if (rise_p) begin
        if (edge_cnt == EDGE_MAX) sat <= 1'b1;
        else                      edge_cnt <= edge_cnt + 1'b1;
      end
    end else if (state != S_LATCH) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
    end
  end

  always_ff @(posedge clkin_50m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dead_cnt <= '0;
    end else if (state == S_DEAD) begin
      dead_cnt <= (dead_cnt == DEAD_LAST) ? '0 : dead_cnt + 1'b1;
    end else begin
      dead_cnt <= '0;
    end
  end

  always_ff @(posedge clkin_50m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      freq_data <= '0;
      overflow  <= 1'b0;
    end else if (state == S_LATCH) begin
      freq_data <= edge_cnt;
      overflow  <= sat;
    end
  end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Bench for freq_gate_counter: a 30-bit and a 6-bit instance share all stimulus;
// a window-arithmetic model predicts every latched count and per-cycle status.
module tb_freq_gate_counter;
  import cymometer_pkg::*;

  localparam int GATE = 1000;
  localparam int DEAD = 16;
  localparam int P    = GATE + 1 + DEAD;
  localparam int W    = 30;
  localparam int WB   = 6;
  localparam int MAXC = 65536;
  localparam int BMAX = (1 << WB) - 1;
  localparam int NEVER = 32'h7fff_ffff;

  localparam int M_PER = 0, M_HIGH = 1, M_LOW = 2, M_PULSE = 3, M_RAND = 4;

  logic clk;
  logic rst_n;
  logic sig_in;
  logic en;

  logic [W-1:0]  freq_a;
  logic          valid_a, ovf_a, gate_a;
  logic [1:0]    state_a;
  logic [WB-1:0] freq_b;
  logic          valid_b, ovf_b, gate_b;
  logic [1:0]    state_b;

  freq_gate_counter #(.GATE_CYCLES(GATE), .DEAD_CYCLES(DEAD), .DATA_W(W)) dut_a (
    .clkin_50m(clk), .sys_rst_n(rst_n), .sig_in(sig_in), .en(en),
    .freq_data(freq_a), .data_valid(valid_a), .overflow(ovf_a),
    .gate_active(gate_a), .fsm_state(state_a)
  );

  freq_gate_counter #(.GATE_CYCLES(GATE), .DEAD_CYCLES(DEAD), .DATA_W(WB)) dut_b (
    .clkin_50m(clk), .sys_rst_n(rst_n), .sig_in(sig_in), .en(en),
    .freq_data(freq_b), .data_valid(valid_b), .overflow(ovf_b),
    .gate_active(gate_b), .fsm_state(state_b)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model state ----------------
  int  cyc = 0;
  bit  s_hist [MAXC];        // value captured by the first sync flop at each edge
  int  checks = 0;
  int  errors = 0;
  bit  run_on = 0;
  int  e_cyc = 0;            // edge on which the FSM entered its first gate
  int  run_end = NEVER;      // first edge after which the FSM is idle again
  logic [W-1:0] exp_q[$];
  logic [W-1:0]  held_a = '0;
  logic [WB-1:0] held_b = '0;
  logic          held_ovf_b = 1'b0;

  int mode = M_LOW, hi_len = 1, lo_len = 1, ph_cnt = 0, rnd_left = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc < MAXC) s_hist[cyc] = rst_n ? sig_in : 1'b0;
  end

  function automatic int count_rises(input int lo, input int hi);
    int n = 0;
    for (int r = lo; r <= hi; r++)
      if (r >= 1 && r < MAXC && s_hist[r] && !s_hist[r-1]) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    run_on = 0;
    run_end = NEVER;
    exp_q.delete();
    held_a = '0;
    held_b = '0;
    held_ovf_b = 1'b0;
  endtask

  // Predict this cycle's status from the gate schedule and compare everything.
  task automatic check_cycle();
    logic [W-1:0] c;
    logic ev, eg;
    logic [1:0] es;
    int rel, ph, n;
    if (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      held_a = c;
      held_b = (c > BMAX) ? WB'(BMAX) : c[WB-1:0];
      held_ovf_b = (c > BMAX);
    end
    ev = 0; eg = 0; es = S_IDLE;
    if (run_on && cyc >= e_cyc && cyc < run_end) begin
      rel = cyc - e_cyc;
      ph = rel % P;
      if (ph < GATE) begin
        eg = 1; es = S_GATE;
      end else if (ph == GATE) begin
        ev = 1; es = S_LATCH;
        n = count_rises(cyc - GATE - 1, cyc - 2);
        exp_q.push_back(W'(n));
      end else begin
        es = S_DEAD;
      end
    end
    check("valid_a", valid_a, ev);
    check("gate_a", gate_a, eg);
    check("state_a", state_a, es);
    check("freq_a", freq_a, held_a);
    check("ovf_a", ovf_a, 1'b0);
    check("valid_b", valid_b, ev);
    check("freq_b", freq_b, held_b);
    check("ovf_b", ovf_b, held_ovf_b);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_sig();
    case (mode)
      M_PER: begin
        sig_in = (ph_cnt < hi_len);
        ph_cnt = (ph_cnt + 1 >= hi_len + lo_len) ? 0 : ph_cnt + 1;
      end
      M_HIGH: sig_in = 1'b1;
      M_LOW:  sig_in = 1'b0;
      M_PULSE: sig_in = run_on && (((cyc + 1 - e_cyc) % P) == hi_len);
      default: begin
        if (rnd_left == 0) begin
          sig_in = ~sig_in;
          rnd_left = $urandom_range(1, 6);
        end
        rnd_left--;
      end
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    drive_sig();
  endtask

  task automatic set_mode(input int m, input int hi, input int lo);
    mode = m; hi_len = hi; lo_len = lo; ph_cnt = 0; rnd_left = 0;
  endtask

  task automatic start_run();
    en = 1'b1;
    run_on = 1;
    e_cyc = cyc + 1;
    run_end = NEVER;
  endtask

  task automatic drop_en();
    int ph;
    ph = (cyc - e_cyc) % P;
    en = 1'b0;
    if (ph < GATE) run_end = cyc + 1;
    else           run_end = e_cyc + ((cyc - e_cyc) / P + 1) * P;
  endtask

  task automatic step_to_phase(input int target);
    for (int i = 0; i < P && ((cyc - e_cyc) % P) != target; i++) step();
    check("phase_reached", (cyc - e_cyc) % P, target);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_freq_a"}, freq_a, 0);
    check({tag, "_valid_a"}, valid_a, 0);
    check({tag, "_ovf_a"}, ovf_a, 0);
    check({tag, "_gate_a"}, gate_a, 0);
    check({tag, "_state_a"}, state_a, S_IDLE);
    check({tag, "_freq_b"}, freq_b, 0);
    check({tag, "_ovf_b"}, ovf_b, 0);
    check({tag, "_gate_b"}, gate_b, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int mode; int hi; int lo;
    int exp_a; int exp_b; bit exp_ovf_b;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{M_PER,   5,        5,  100, 63, 1'b1};
    vecs[1] = '{M_PER,   1,        1,  500, 63, 1'b1};
    vecs[2] = '{M_PER,   50,       50, 10,  10, 1'b0};
    vecs[3] = '{M_HIGH,  0,        0,  0,   0,  1'b0};
    vecs[4] = '{M_LOW,   0,        0,  0,   0,  1'b0};
    vecs[5] = '{M_PER,   2,        3,  200, 63, 1'b1};
    vecs[6] = '{M_PULSE, GATE - 2, 0,  1,   1,  1'b0};
    vecs[7] = '{M_PULSE, GATE - 1, 0,  0,   0,  1'b0};
    vecs[8] = '{M_PULSE, GATE + 3, 0,  0,   0,  1'b0};
    vecs[9] = '{M_PER,   10,       10, 50,  50, 1'b0};

    rst_n = 1'b0; en = 1'b0; sig_in = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) step();

    // Continuous measurement; each row gets two gates, the second is judged.
    start_run();
    for (int i = 0; i < 10; i++) begin
      set_mode(vecs[i].mode, vecs[i].hi, vecs[i].lo);
      repeat (2 * P) step();
      check($sformatf("row%0d_freq_a", i), freq_a, vecs[i].exp_a);
      check($sformatf("row%0d_freq_b", i), freq_b, vecs[i].exp_b);
      check($sformatf("row%0d_ovf_b", i), ovf_b, vecs[i].exp_ovf_b);
    end

    set_mode(M_RAND, 0, 0);
    repeat (3 * P) step();

    // Drop en half way through a gate after a result of 100.
    set_mode(M_PER, 5, 5);
    repeat (2 * P) step();
    check("prior_result", freq_a, 100);
    step_to_phase(500);
    drop_en();
    repeat (P + 5) step();
    check("drop_freq_hold", freq_a, 100);
    check("drop_state", state_a, S_IDLE);

    // Restart: a full gate, then drop en while in S_LATCH.
    start_run();
    repeat (P) step();
    check("restart_freq", freq_a, 100);
    step_to_phase(GATE);
    drop_en();
    repeat (DEAD + 4) step();
    check("latch_drop_state", state_a, S_IDLE);
    check("latch_drop_freq", freq_a, 100);

    // Asynchronous reset in the middle of a gate.
    start_run();
    step_to_phase(400);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_run();
    repeat (2 * P) step();
    check("post_reset_freq", freq_a, 100);
    step_to_phase(200);
    drop_en();
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
